// File: rtl/rv_alu_pipe.sv
// rv_alu_pipe: four-stage (ID/EX/MEM/WB) RV32 integer ALU pipeline with register file.
// Define RV_ALU_PIPE_FWD_EN for EX/MEM->ID forwarding; otherwise ID stalls on RAW hazards.
module rv_alu_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int RA   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            insn_valid,
  input  logic [31:0]     insn,
  output logic            insn_ready,
  output logic            wb_valid,
  output logic [RA-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output logic [31:0]     retired,
  input  logic [RA-1:0]   dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);
  localparam int SW = $clog2(XLEN);

  typedef struct packed {
    logic            is_r;
    logic [2:0]      f3;
    logic            alt;
    logic [RA-1:0]   rs1;
    logic [RA-1:0]   rs2;
    logic [RA-1:0]   rd;
    logic [XLEN-1:0] imm;
  } dec_t;

  logic [XLEN-1:0] rf_q [NREGS];

  logic            id_valid_q, id_valid_d;
  dec_t            id_q;
  logic            ex_valid_q, ex_valid_d;
  logic [2:0]      ex_f3_q;
  logic            ex_alt_q;
  logic [RA-1:0]   ex_rd_q;
  logic [XLEN-1:0] ex_a_q, ex_b_q, ex_res;
  logic            mem_valid_q;
  logic [RA-1:0]   mem_rd_q;
  logic [XLEN-1:0] mem_res_q;
  logic            wb_vld_q;
  logic [RA-1:0]   wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic            illegal_q, illegal_d;
  logic [31:0]     retired_q, retired_d;

  dec_t            in_dec;
  logic            in_legal;
  logic            hi_rs1, hi_rs2, hi_rd;
  logic [6:0]      opc, f7;
  logic            stall, accept;
  logic [XLEN-1:0] op_a, op_r2, op_b;

  assign opc = insn[6:0];
  assign f7  = insn[31:25];

  // Decode at issue; an unsupported word never occupies a stage.
  always_comb begin
    in_dec      = '0;
    in_legal    = 1'b0;
    in_dec.f3   = insn[14:12];
    in_dec.rs1  = insn[15 +: RA];
    in_dec.rs2  = insn[20 +: RA];
    in_dec.rd   = insn[7 +: RA];
    in_dec.imm  = {{(XLEN-12){insn[31]}}, insn[31:20]};
    hi_rs1      = (insn[19:15] >> RA) != 5'd0;
    hi_rs2      = (insn[24:20] >> RA) != 5'd0;
    hi_rd       = (insn[11:7]  >> RA) != 5'd0;
    case (opc)
      7'b0010011: begin
        case (insn[14:12])
          3'b001:  in_legal = (f7 == 7'b0000000);
          3'b101: begin
            in_legal   = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            in_dec.alt = f7[5];
          end
          default: in_legal = 1'b1;
        endcase
        in_legal = in_legal && !hi_rs1 && !hi_rd;
      end
      7'b0110011: begin
        in_dec.is_r = 1'b1;
        in_dec.alt  = f7[5];
        in_legal    = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((insn[14:12] == 3'b000) || (insn[14:12] == 3'b101)));
        in_legal    = in_legal && !hi_rs1 && !hi_rs2 && !hi_rd;
      end
      default: in_legal = 1'b0;
    endcase
  end

`ifdef RV_ALU_PIPE_FWD_EN
  assign stall = 1'b0;
`else
  logic haz1, haz2;
  always_comb begin
    haz1  = (id_q.rs1 != '0) &&
            ((ex_valid_q && (ex_rd_q == id_q.rs1)) || (mem_valid_q && (mem_rd_q == id_q.rs1)));
    haz2  = id_q.is_r && (id_q.rs2 != '0) &&
            ((ex_valid_q && (ex_rd_q == id_q.rs2)) || (mem_valid_q && (mem_rd_q == id_q.rs2)));
    stall = id_valid_q && (haz1 || haz2);
  end
`endif

  assign insn_ready = !rst && !stall;
  assign accept     = insn_valid && insn_ready;

  // Register file is written at the WB edge, so a reader in ID one cycle later sees it directly.
  always_comb begin
    op_a  = (id_q.rs1 == '0) ? '0 : rf_q[id_q.rs1];
    op_r2 = (id_q.rs2 == '0) ? '0 : rf_q[id_q.rs2];
`ifdef RV_ALU_PIPE_FWD_EN
    if (id_q.rs1 != '0) begin
      if (ex_valid_q && (ex_rd_q == id_q.rs1))        op_a = ex_res;
      else if (mem_valid_q && (mem_rd_q == id_q.rs1)) op_a = mem_res_q;
    end
    if (id_q.rs2 != '0) begin
      if (ex_valid_q && (ex_rd_q == id_q.rs2))        op_r2 = ex_res;
      else if (mem_valid_q && (mem_rd_q == id_q.rs2)) op_r2 = mem_res_q;
    end
`endif
    op_b = id_q.is_r ? op_r2 : id_q.imm;
  end

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] sra_res;
  always_comb begin
    shamt   = ex_b_q[SW-1:0];
    sra_res = $signed(ex_a_q) >>> shamt;
    ex_res  = '0;
    case (ex_f3_q)
      3'b000: begin
        if (ex_alt_q) ex_res = ex_a_q - ex_b_q;
        else          ex_res = ex_a_q + ex_b_q;
      end
      3'b001: ex_res = ex_a_q << shamt;
      3'b010: ex_res = {{(XLEN-1){1'b0}}, $signed(ex_a_q) < $signed(ex_b_q)};
      3'b011: ex_res = {{(XLEN-1){1'b0}}, ex_a_q < ex_b_q};
      3'b100: ex_res = ex_a_q ^ ex_b_q;
      3'b101: begin
        if (ex_alt_q) ex_res = sra_res;
        else          ex_res = ex_a_q >> shamt;
      end
      3'b110: ex_res = ex_a_q | ex_b_q;
      default: ex_res = ex_a_q & ex_b_q;
    endcase
  end

  always_comb begin
    id_valid_d = stall ? id_valid_q : (accept && in_legal);
    ex_valid_d = id_valid_q && !stall;
    illegal_d  = illegal_q || (accept && !in_legal);
    retired_d  = mem_valid_q ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q  <= 1'b0;
      id_q        <= '0;
      ex_valid_q  <= 1'b0;
      ex_f3_q     <= '0;
      ex_alt_q    <= 1'b0;
      ex_rd_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_res_q   <= '0;
      wb_vld_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[RA'(i)] <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      if (!stall) id_q <= in_dec;
      ex_valid_q  <= ex_valid_d;
      ex_f3_q     <= id_q.f3;
      ex_alt_q    <= id_q.alt;
      ex_rd_q     <= id_q.rd;
      ex_a_q      <= op_a;
      ex_b_q      <= op_b;
      mem_valid_q <= ex_valid_q;
      mem_rd_q    <= ex_rd_q;
      mem_res_q   <= ex_res;
      wb_vld_q    <= mem_valid_q;
      wb_rd_q     <= mem_rd_q;
      wb_data_q   <= mem_res_q;
      illegal_q   <= illegal_d;
      retired_q   <= retired_d;
      if (mem_valid_q && (mem_rd_q != '0)) rf_q[mem_rd_q] <= mem_res_q;
    end
  end

  // x0 writes still occupy WB and retire, but never pulse wb_valid.
  assign wb_valid  = wb_vld_q && (wb_rd_q != '0);
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : rf_q[dbg_raddr];

endmodule

// File: tb/tb_rv_alu_pipe.sv
// tb_rv_alu_pipe: directed-vector bench for rv_alu_pipe (32-bit/32-reg and 16-bit/8-reg instances).
module tb_rv_alu_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        iv, iv16;
  logic [31:0] iw, iw16;
  logic        rdy, rdy16, wbv, wbv16, ill, ill16;
  logic [4:0]  wbrd, dba;
  logic [2:0]  wbrd16, dba16;
  logic [31:0] wbd, ret, ret16, dbd;
  logic [15:0] wbd16, dbd16;

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned wb_cnt = 0, low_cnt = 0;
  int unsigned exp_ret [2];
  int unsigned w0, l0;
  bit          fwd;

  rv_alu_pipe #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .insn_valid(iv), .insn(iw), .insn_ready(rdy),
    .wb_valid(wbv), .wb_rd(wbrd), .wb_data(wbd), .illegal(ill), .retired(ret),
    .dbg_raddr(dba), .dbg_rdata(dbd)
  );

  rv_alu_pipe #(.XLEN(16), .NREGS(8)) dut16 (
    .clk(clk), .rst(rst), .insn_valid(iv16), .insn(iw16), .insn_ready(rdy16),
    .wb_valid(wbv16), .wb_rd(wbrd16), .wb_data(wbd16), .illegal(ill16), .retired(ret16),
    .dbg_raddr(dba16), .dbg_rdata(dbd16)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wbv) wb_cnt++;
    if (!rst && !rdy) low_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ityp(input int f3, input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] rtyp(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  task automatic issue(input bit sel, input logic [31:0] w, input bit legal);
    int unsigned n = 0;
    @(negedge clk);
    if (sel) begin iv16 = 1'b1; iw16 = w; end
    else     begin iv   = 1'b1; iw   = w; end
    while (((sel ? rdy16 : rdy) == 1'b0) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("issue_wait", 64'(sel ? rdy16 : rdy), 64'd1);
    @(posedge clk);
    #1;
    iv   = 1'b0;
    iv16 = 1'b0;
    if (legal) exp_ret[sel]++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reg(input bit sel, input int r, input logic [31:0] exp, input string tag);
    if (sel) dba16 = 3'(r);
    else     dba   = 5'(r);
    #1;
    check_eq($sformatf("%s_x%0d", tag, r), sel ? 64'(dbd16) : 64'(dbd), 64'(exp));
  endtask

  initial begin
    fwd = 1'b0;
`ifdef RV_ALU_PIPE_FWD_EN
    fwd = 1'b1;
`endif
    rst = 1'b1; iv = 1'b0; iv16 = 1'b0; iw = '0; iw16 = '0; dba = '0; dba16 = '0;
    exp_ret[0] = 0; exp_ret[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready",   64'(rdy), 64'd0);
    check_eq("rst_wbvalid", 64'(wbv), 64'd0);
    check_eq("rst_wbdata",  64'(wbd), 64'd0);
    check_eq("rst_illegal", 64'(ill), 64'd0);
    check_eq("rst_retired", 64'(ret), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst",   64'(rdy),   64'd1);
    check_eq("ready16_after_rst", 64'(rdy16), 64'd1);

    // Two independent ADDIs: latency and write-back values.
    issue(0, ityp(0, 1, 0, 5), 1);
    issue(0, ityp(0, 2, 0, -3), 1);
    @(posedge clk); @(negedge clk);
    check_eq("lat_wb_early", 64'(wbv), 64'd0);
    @(negedge clk);
    check_eq("wb1_valid", 64'(wbv),  64'd1);
    check_eq("wb1_rd",    64'(wbrd), 64'd1);
    check_eq("wb1_data",  64'(wbd),  64'd5);
    @(negedge clk);
    check_eq("wb2_valid", 64'(wbv),  64'd1);
    check_eq("wb2_rd",    64'(wbrd), 64'd2);
    check_eq("wb2_data",  64'(wbd),  64'hFFFF_FFFD);
    idle(3);
    check_eq("retired_2", 64'(ret), 64'(exp_ret[0]));
    chk_reg(0, 2, 32'hFFFF_FFFD, "addi_neg");

    // RAW dependency back-to-back: stall count depends on forwarding.
    l0 = low_cnt;
    issue(0, ityp(0, 1, 0, 7), 1);
    issue(0, rtyp(0, 0, 2, 1, 1), 1);
    idle(6);
    check_eq("stall_cycles", 64'(low_cnt - l0), fwd ? 64'd0 : 64'd2);
    chk_reg(0, 2, 32'd14, "raw_add");

    // ALU operations on x1 = 0x80000000, x2 = 1.
    issue(0, ityp(0, 1, 0, 1), 1);
    issue(0, ityp(1, 1, 1, 31), 1);
    issue(0, ityp(0, 2, 0, 1), 1);
    issue(0, rtyp(0, 2, 3, 1, 2), 1);
    issue(0, rtyp(0, 3, 4, 1, 2), 1);
    issue(0, ityp(5, 5, 1, 'h404), 1);
    issue(0, ityp(5, 6, 1, 4), 1);
    issue(0, rtyp('h20, 0, 7, 2, 1), 1);
    issue(0, ityp(4, 8, 2, -1), 1);
    issue(0, ityp(6, 9, 6, 'h7FF), 1);
    issue(0, ityp(3, 10, 2, -1), 1);
    issue(0, ityp(2, 11, 1, 0), 1);
    issue(0, rtyp('h20, 5, 12, 1, 2), 1);
    issue(0, rtyp(0, 7, 13, 5, 6), 1);
    issue(0, rtyp(0, 6, 14, 2, 6), 1);
    issue(0, ityp(7, 15, 9, -16), 1);
    issue(0, rtyp(0, 5, 16, 1, 2), 1);
    issue(0, rtyp(0, 4, 17, 1, 5), 1);
    issue(0, ityp(0, 19, 0, 33), 1);
    issue(0, rtyp(0, 1, 18, 2, 19), 1);
    issue(0, rtyp(0, 0, 20, 1, 1), 1);
    idle(6);
    chk_reg(0, 1,  32'h8000_0000, "slli");
    chk_reg(0, 3,  32'h0000_0001, "slt");
    chk_reg(0, 4,  32'h0000_0000, "sltu");
    chk_reg(0, 5,  32'hF800_0000, "srai");
    chk_reg(0, 6,  32'h0800_0000, "srli");
    chk_reg(0, 7,  32'h8000_0001, "sub");
    chk_reg(0, 8,  32'hFFFF_FFFE, "xori");
    chk_reg(0, 9,  32'h0800_07FF, "ori");
    chk_reg(0, 10, 32'h0000_0001, "sltiu");
    chk_reg(0, 11, 32'h0000_0001, "slti");
    chk_reg(0, 12, 32'hC000_0000, "sra");
    chk_reg(0, 13, 32'h0800_0000, "and");
    chk_reg(0, 14, 32'h0800_0001, "or");
    chk_reg(0, 15, 32'h0800_07F0, "andi");
    chk_reg(0, 16, 32'h4000_0000, "srl");
    chk_reg(0, 17, 32'h7800_0000, "xor");
    chk_reg(0, 18, 32'h0000_0002, "sll_mask");
    chk_reg(0, 20, 32'h0000_0000, "add_wrap");
    check_eq("retired_alu", 64'(ret), 64'(exp_ret[0]));

    // Illegal words become bubbles; x0 write retires without a pulse.
    w0 = wb_cnt;
    issue(0, 32'h0000_007F, 0);
    @(negedge clk);
    check_eq("illegal_set", 64'(ill), 64'd1);
    issue(0, ityp(0, 0, 0, 9), 1);
    issue(0, rtyp(1, 0, 21, 2, 2), 0);
    issue(0, ityp(1, 22, 2, 'h401), 0);
    idle(6);
    check_eq("x0_no_pulse",    64'(wb_cnt - w0), 64'd0);
    check_eq("illegal_sticky", 64'(ill), 64'd1);
    check_eq("retired_ill",    64'(ret), 64'(exp_ret[0]));
    chk_reg(0, 0,  32'd0, "x0");
    chk_reg(0, 21, 32'd0, "bad_f7");
    chk_reg(0, 22, 32'd0, "bad_slli");

    // Reset with three instructions in flight.
    w0 = wb_cnt;
    issue(0, ityp(0, 1, 0, 1), 1);
    issue(0, ityp(0, 2, 0, 2), 1);
    issue(0, ityp(0, 3, 0, 3), 1);
    rst = 1'b1;
    exp_ret[0] = 0;
    @(negedge clk);
    check_eq("midrst_ready", 64'(rdy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_ready_after", 64'(rdy), 64'd1);
    idle(5);
    check_eq("midrst_no_wb",   64'(wb_cnt - w0), 64'd0);
    check_eq("midrst_retired", 64'(ret), 64'd0);
    check_eq("midrst_illegal", 64'(ill), 64'd0);
    for (int r = 0; r < 32; r++) chk_reg(0, r, 32'd0, "midrst");

    // 16-bit datapath, 8 registers.
    issue(1, ityp(0, 1, 0, -1), 1);
    issue(1, ityp(1, 2, 1, 15), 1);
    issue(1, ityp(5, 3, 2, 'h40F), 1);
    issue(1, ityp(1, 4, 1, 17), 1);
    check_eq("ill16_pre", 64'(ill16), 64'd0);
    issue(1, ityp(0, 9, 0, 1), 0);
    idle(6);
    chk_reg(1, 1, 32'h0000_FFFF, "x16");
    chk_reg(1, 2, 32'h0000_8000, "x16_slli");
    chk_reg(1, 3, 32'h0000_FFFF, "x16_srai");
    chk_reg(1, 4, 32'h0000_FFFE, "x16_shmask");
    check_eq("ill16_rd9",   64'(ill16), 64'd1);
    check_eq("retired16",   64'(ret16), 64'(exp_ret[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
